// File: rtl/param_fifo_pkg.sv
// Shared definitions for param_sync_fifo.
// Purpose : clog2, pointer/count width derivation, default sizes and a
//           parameter legality check used at elaboration time.
// Ports   : none (package).
package param_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 32'd8;
  localparam int unsigned DEF_DEPTH  = 32'd16;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 32'd1;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth) + 32'd1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic bit params_legal(input int unsigned data_w,
                                      input int unsigned depth,
                                      input int unsigned af_thresh,
                                      input int unsigned ae_thresh);
    return (data_w >= 32'd1) && is_pow2(depth) &&
           (af_thresh >= 32'd1) && (af_thresh <= depth) &&
           (ae_thresh <= depth - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage array for param_sync_fifo.
// Purpose : DEPTH x DATA_W array, synchronous write port and one read port.
//           REG_RD=1 gives a registered read (updates only when rd_en is
//           high, clears on reset); REG_RD=0 gives a combinational read.
// Ports   : clk, rst_n (async active-low, read register only),
//           wr_en/wr_addr/wr_data (write port),
//           rd_en/rd_addr (read port), rd_data (read data).
module fifo_ram_2p #(
  parameter int unsigned DATA_W = 32'd8,
  parameter int unsigned DEPTH  = 32'd16,
  parameter int unsigned ADDR_W = 32'd4,
  parameter bit          REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [DATA_W-1:0] rd_data_r;

      // Registered read; holds its value when no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
          rd_data_r <= mem_r[rd_addr];
        end
      end

      assign rd_data = rd_data_r;
    end else begin : g_comb_rd
      // Head word falls straight through; rd_en/rst_n have no role here.
      logic unused_s;
      assign unused_s = rd_en ^ rst_n;
      assign rd_data  = mem_r[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO.
// Purpose : pointers, occupancy count, full/empty/almost flags and
//           overflow/underflow pulses around a fifo_ram_2p array.
// Config  : define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
//           reads (data_o shows the head word combinationally from storage);
//           undefined gives a registered read with one cycle of latency.
// Ports   : clk, reset_i (async active-low), wr_en_i/data_i (write),
//           rd_en_i/data_o (read), full_o, empty_o, almost_full_o,
//           almost_empty_o, count_o (occupancy), overflow_o/underflow_o
//           (one-cycle pulses for a dropped write/read).
module param_sync_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 32'd2,
  parameter int unsigned AE_THRESH = 32'd2
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         wr_en_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         rd_en_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned CNT_W  = cnt_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic             AF_RST  = (AF_THRESH == 32'd0) ? 1'b1 : 1'b0;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
`else
  localparam bit REG_RD = 1'b1;
`endif

  generate
    if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("param_sync_fifo: illegal DATA_W/DEPTH/threshold parameters");
    end
  endgenerate

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             af_r;
  logic             ae_r;
  logic             ovf_r;
  logic             unf_r;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             wr_drop_s;
  logic             rd_drop_s;

  // Acceptance is judged on the registered (pre-edge) flags only.
  assign wr_acc_s  = wr_en_i & ~full_r;
  assign rd_acc_s  = rd_en_i & ~empty_r;
  assign wr_drop_s = wr_en_i & full_r;
  assign rd_drop_s = rd_en_i & empty_r;

  // Next occupancy: a simultaneous accepted write and read cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and flags; flags are registered copies decoded from the
  // next count so they always agree with count_o.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= AF_RST;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      af_r    <= (count_nxt_s >= AF_C);
      ae_r    <= (count_nxt_s <= AE_C);
      ovf_r   <= wr_drop_s;
      unf_r   <= rd_drop_s;
    end
  end

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .REG_RD (REG_RD)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_i),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (data_i),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (data_o)
  );

  assign count_o        = count_r;
  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = af_r;
  assign almost_empty_o = ae_r;
  assign overflow_o     = ovf_r;
  assign underflow_o    = unf_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DATA_W=8, DEPTH=8, AF=6, AE=2).
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       wr_en_i;
  logic [7:0] data_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [3:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic [5:0] flg;
    string      tag;
  } st_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    string      tag;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];

  param_sync_fifo #(
    .DATA_W    (8),
    .DEPTH     (8),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .wr_en_i        (wr_en_i),
    .data_i         (data_i),
    .rd_en_i        (rd_en_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected flag vector {full, empty, af, ae, ovf, unf} for a given count.
  function automatic logic [5:0] fl(input logic [3:0] c, input logic ov, input logic un);
    return {c == 4'd8, c == 4'd0, c >= 4'd6, c <= 4'd2, ov, un};
  endfunction

  // Monitor: compare queued expectations due in the current cycle.
  always @(negedge clk) begin : mon
    st_t s;
    rd_t r;
    logic [5:0] got;
    got = {full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      checks++;
      if (s.cyc != cyc || count_o !== s.cnt || got !== s.flg) begin
        errors++;
        $display("FAIL %s cyc=%0d: count=%0d flags=%b, expected count=%0d flags=%b (due cyc %0d)",
                 s.tag, cyc, count_o, got, s.cnt, s.flg, s.cyc);
      end
    end
    while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      r = rd_q.pop_front();
      checks++;
      if (r.cyc != cyc || data_o !== r.d) begin
        errors++;
        $display("FAIL %s cyc=%0d: data_o=%h, expected %h (due cyc %0d)",
                 r.tag, cyc, data_o, r.d, r.cyc);
      end
    end
  end

  // One clock of stimulus; expectations fall due after the coming edge.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                       input logic [3:0] cnt, input logic ov, input logic un,
                       input logic chk, input logic [7:0] exp_d, input string tag);
    wr_en_i = wr;
    data_i  = d;
    rd_en_i = rd;
    st_q.push_back(st_t'{cyc + 1, cnt, fl(cnt, ov, un), tag});
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    if (chk) rd_q.push_back(rd_t'{cyc + 1, exp_d, tag});
`endif
    @(negedge clk);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  // Immediate check, used where no clock edge is involved.
  task automatic chk_now(input string tag);
    logic [5:0] got;
    got = {full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
    checks++;
    if (count_o !== 4'd0 || got !== fl(4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL %s: count=%0d flags=%b, expected count=0 flags=%b",
               tag, count_o, got, fl(4'd0, 1'b0, 1'b0));
    end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL %s_data: data_o=%h, expected 00", tag, data_o);
    end
`endif
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stim
    reset_i = 1'b0;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_now("reset");
    reset_i = 1'b1;
    @(negedge clk);

    // Fill to full, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00, "fill");
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 4'(7 - i), 1'b0, 1'b0, 1'b1, 8'(8'h10 + i), "drain");

    // Overflow: dropped write while full, and write+read while full.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00, "refill");
    cycle(1'b1, 8'hAA, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 8'h00, "ovf_wr");
    cycle(1'b0, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 8'h00, "ovf_clear");
    cycle(1'b1, 8'hAB, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 8'h20, "ovf_wrrd");
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 4'(6 - i), 1'b0, 1'b0, 1'b1, 8'(8'h21 + i), "ovf_drain");

    // Underflow: read while empty, then write+read while empty.
    cycle(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'h27, "unf_rd");
    cycle(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h27, "unf_clear");
    cycle(1'b1, 8'h55, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 8'h27, "unf_wrrd");
    cycle(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 8'h55, "unf_pop");

    // Steady state at count 4 with pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00, "wrap_fill");
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h34 + i), 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 8'(8'h30 + i), "wrap_wrrd");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 4'(3 - i), 1'b0, 1'b0, 1'b1, 8'(8'h44 + i), "wrap_drain");

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00, "burst");
    wr_en_i = 1'b1;
    data_i  = 8'h65;
    #2;
    reset_i = 1'b0;
    #1;
    chk_now("rst_async");
    @(negedge clk);
    @(negedge clk);
    wr_en_i = 1'b0;
    chk_now("rst_hold");
    reset_i = 1'b1;
    @(negedge clk);
    cycle(1'b1, 8'h3C, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, "post_rst_wr");
    cycle(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 8'h3C, "post_rst_rd");

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Fall-through: written word appears without a read request.
    rd_q.push_back(rd_t'{cyc + 1, 8'h77, "fwft_show"});
    cycle(1'b1, 8'h77, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, "fwft_wr");
    rd_q.push_back(rd_t'{cyc + 1, 8'h77, "fwft_hold"});
    cycle(1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, "fwft_idle");
    cycle(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, "fwft_pop");
`endif

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queues: %0d status and %0d data expectations left, expected 0 and 0",
               st_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
